// File: rtl/core_pkg.sv
// Shared core types: ROB writeback widths, writeback payload struct, round-robin helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package core_pkg;

   localparam int ROBID_W  = 7;
   localparam int ECAUSE_W = 5;
   localparam int XLEN     = 32;

   typedef struct packed {
      logic                error;
      logic [ECAUSE_W-1:0] ecause;
      logic [ROBID_W-1:0]  robid;
      logic [XLEN-1:0]     result;
   } wb_req_t;

   // Index one past the winner, wrapping at n, so the winner becomes lowest priority next.
   function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
      return (g + 1) % n;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of per-unit writeback requests plus the single ROB writeback port.
// Latency: n/a (wires only).
// Backpressure: req_ready per unit; the ROB side has no backpressure.
interface wb_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int ROBID_W  = core_pkg::ROBID_W,
   parameter int ECAUSE_W = core_pkg::ECAUSE_W,
   parameter int XLEN     = core_pkg::XLEN
);
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ-1:0]          req_error;
   logic [NUM_REQ*ECAUSE_W-1:0] req_ecause;
   logic [NUM_REQ*ROBID_W-1:0]  req_robid;
   logic [NUM_REQ*XLEN-1:0]     req_result;

   logic                        wb_valid;
   logic                        wb_error;
   logic [ECAUSE_W-1:0]         wb_ecause;
   logic [ROBID_W-1:0]          wb_robid;
   logic [XLEN-1:0]             wb_result;

   // Execution-unit side (drives requests, observes writeback).
   modport master (
      output req_valid, req_error, req_ecause, req_robid, req_result,
      input  req_ready, wb_valid, wb_error, wb_ecause, wb_robid, wb_result
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_error, req_ecause, req_robid, req_result,
      output req_ready, wb_valid, wb_error, wb_ecause, wb_robid, wb_result
   );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin one-hot arbiter: first set request at or above ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none; grant is all-zero when no request is set.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] grant_idx_o
);

   logic found;
   int   cand;

   // Walk the candidates starting at the pointer; the first valid one wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr_i) + k) % N;
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            grant_o[cand]  = 1'b1;
            grant_idx_o    = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the ROB writeback port among NUM_REQ units via one holding slot each and RR drain.
// Latency: 2 cycles minimum from request beat to wb_valid (slot capture, then output register).
// Backpressure: req_ready drops while a unit's slot is full and not granted, and during rob_flush.
module wb_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ROBID_W  = core_pkg::ROBID_W,
   parameter int ECAUSE_W = core_pkg::ECAUSE_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rob_flush,
   wb_arbiter_if.slave bus
);
   import core_pkg::*;

   localparam int PW = $clog2(NUM_REQ);

   typedef struct packed {
      logic                error;
      logic [ECAUSE_W-1:0] ecause;
      logic [ROBID_W-1:0]  robid;
      logic [XLEN-1:0]     result;
   } slot_t;

   slot_t              slot_q [NUM_REQ];
   slot_t              slot_d [NUM_REQ];
   logic [NUM_REQ-1:0] slot_vld_q, slot_vld_d;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] accept;
   logic [PW-1:0]      grant_idx;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic               any_grant;
   slot_t              wb_q;
   logic               wb_vld_q;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i       (slot_vld_q),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   assign any_grant     = |grant;
   // A slot being drained this cycle can take the next beat, giving 1/cycle per unit.
   assign bus.req_ready = {NUM_REQ{~rob_flush}} & (~slot_vld_q | grant);
   assign accept        = bus.req_valid & bus.req_ready;

   // Next slot contents: flush empties everything, a refill beats a drain.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         slot_d[i]     = slot_q[i];
         slot_vld_d[i] = slot_vld_q[i];
         if (rob_flush) begin
            slot_vld_d[i] = 1'b0;
         end else if (accept[i]) begin
            slot_vld_d[i]       = 1'b1;
            slot_d[i].error     = bus.req_error[i];
            slot_d[i].ecause    = bus.req_ecause[i*ECAUSE_W +: ECAUSE_W];
            slot_d[i].robid     = bus.req_robid[i*ROBID_W +: ROBID_W];
            slot_d[i].result    = bus.req_result[i*XLEN +: XLEN];
         end else if (grant[i]) begin
            slot_vld_d[i] = 1'b0;
         end
      end
   end

   // Pointer moves past the winner; flush leaves it alone.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_grant) begin
         rr_ptr_d = PW'(rr_next(32'(grant_idx), NUM_REQ));
      end
   end

   // Slot and pointer state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_vld_q <= '0;
         rr_ptr_q   <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         slot_vld_q <= slot_vld_d;
         rr_ptr_q   <= rr_ptr_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   // Registered writeback stage; data holds when idle, a flush-cycle grant is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_vld_q <= 1'b0;
         wb_q     <= '0;
      end else begin
         wb_vld_q <= any_grant & ~rob_flush;
         if (any_grant) begin
            wb_q <= slot_q[grant_idx];
         end
      end
   end

   assign bus.wb_valid  = wb_vld_q;
   assign bus.wb_error  = wb_q.error;
   assign bus.wb_ecause = wb_q.ecause;
   assign bus.wb_robid  = wb_q.robid;
   assign bus.wb_result = wb_q.result;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus, expected writebacks queued at issue time,
// a negedge monitor pops and compares every wb_valid beat; direct checks cover latency,
// readiness, flush and reset behaviour.
module tb_wb_arbiter;
   import core_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   logic rob_flush;

   always #5 clk = ~clk;

   wb_arbiter_if #(.NUM_REQ(N)) bus ();

   wb_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .rob_flush (rob_flush),
      .bus       (bus.slave)
   );

   int      checks   = 0;
   int      failures = 0;
   wb_req_t exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int u, input logic err, input logic [4:0] ec,
                        input logic [6:0] rid, input logic [31:0] res);
      bus.req_valid[u]           = 1'b1;
      bus.req_error[u]           = err;
      bus.req_ecause[u*5 +: 5]   = ec;
      bus.req_robid[u*7 +: 7]    = rid;
      bus.req_result[u*32 +: 32] = res;
   endtask

   task automatic push(input logic err, input logic [4:0] ec,
                       input logic [6:0] rid, input logic [31:0] res);
      wb_req_t e;
      e.error  = err;
      e.ecause = ec;
      e.robid  = rid;
      e.result = res;
      exp_q.push_back(e);
   endtask

   // Monitor: every writeback beat must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.wb_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: got robid=%0h result=%0h, none expected at %0t",
                     bus.wb_robid, bus.wb_result, $time);
         end else begin
            wb_req_t e;
            e = exp_q.pop_front();
            if (bus.wb_error !== e.error || bus.wb_ecause !== e.ecause ||
                bus.wb_robid !== e.robid || bus.wb_result !== e.result) begin
               failures++;
               $display("FAIL wb_data: got err=%0b ec=%0h robid=%0h result=%0h expected err=%0b ec=%0h robid=%0h result=%0h at %0t",
                        bus.wb_error, bus.wb_ecause, bus.wb_robid, bus.wb_result,
                        e.error, e.ecause, e.robid, e.result, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c, k, zeros;
      logic rdy;

      rst            = 1'b1;
      rob_flush      = 1'b0;
      bus.req_valid  = '0;
      bus.req_error  = '0;
      bus.req_ecause = '0;
      bus.req_robid  = '0;
      bus.req_result = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_wb_valid",  bus.wb_valid, 0);
      chk("rst_wb_robid",  bus.wb_robid, 0);
      chk("rst_wb_result", bus.wb_result, 0);
      chk("rst_wb_err_ec", {bus.wb_error, bus.wb_ecause}, 0);
      chk("rst_req_ready", bus.req_ready, 4'hF);

      // Contention: all four at once, pointer 0 -> order 0,1,2,3
      tick();
      for (int u = 0; u < N; u++) begin
         drive(u, 1'b0, 5'd0, 7'(8'h10 + u), 32'h1000_0000 + u);
         push(1'b0, 5'd0, 7'(8'h10 + u), 32'h1000_0000 + u);
      end
      @(negedge clk);
      chk("cont_ready", bus.req_ready, 4'hF);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("cont_t1_idle", bus.wb_valid, 0);
      for (int t = 2; t <= 5; t++) begin
         tick();
         @(negedge clk);
         chk("cont_vld", bus.wb_valid, 1);
      end
      tick();
      @(negedge clk);
      chk("cont_done", bus.wb_valid, 0);

      // Single request, unit 2, minimum latency
      tick();
      drive(2, 1'b0, 5'd0, 7'h15, 32'hDEAD_BEEF);
      push(1'b0, 5'd0, 7'h15, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("single_rdy_t0", bus.req_ready[2], 1);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("single_rdy_t1", bus.req_ready[2], 1);
      chk("single_t1_idle", bus.wb_valid, 0);
      tick();
      @(negedge clk);
      chk("single_t2_vld", bus.wb_valid, 1);
      chk("single_t2_robid", bus.wb_robid, 7'h15);
      chk("single_rdy_t2", bus.req_ready[2], 1);
      repeat (3) tick();

      // Streaming unit 0 plus one request from unit 3 (pointer now 3)
      push(1'b0, 5'd0, 7'h33, 32'h3333_0003);
      drive(3, 1'b0, 5'd0, 7'h33, 32'h3333_0003);
      drive(0, 1'b0, 5'd0, 7'h40, 32'hA000_0000);
      c = 0; k = 0; zeros = 0;
      while (k < 6 && c < 20) begin
         @(negedge clk);
         rdy = bus.req_ready[0];
         if (c == 2) begin
            chk("fair_u3_vld", bus.wb_valid, 1);
            chk("fair_u3_robid", bus.wb_robid, 7'h33);
         end
         if (!rdy) zeros++;
         if (rdy) push(1'b0, 5'd0, 7'(8'h40 + k), 32'hA000_0000 + k);
         tick();
         c++;
         if (c == 1) bus.req_valid[3] = 1'b0;
         if (rdy) begin
            k++;
            if (k < 6) drive(0, 1'b0, 5'd0, 7'(8'h40 + k), 32'hA000_0000 + k);
            else       bus.req_valid[0] = 1'b0;
         end
      end
      chk("stream_all_accepted", k, 6);
      chk("stream_lost_cycles", zeros, 1);
      repeat (8) tick();

      // Exception pass-through on unit 1, then robid 0x00 back to back
      drive(1, 1'b1, 5'd2, 7'h7F, 32'h0BAD_F00D);
      push(1'b1, 5'd2, 7'h7F, 32'h0BAD_F00D);
      tick();
      drive(1, 1'b0, 5'd0, 7'h00, 32'h0000_0001);
      push(1'b0, 5'd0, 7'h00, 32'h0000_0001);
      @(negedge clk);
      chk("exc_b2b_ready", bus.req_ready[1], 1);
      tick();
      bus.req_valid = '0;
      bus.req_error = '0;
      @(negedge clk);
      chk("exc_error", bus.wb_error, 1);
      chk("exc_ecause", bus.wb_ecause, 5'd2);
      chk("exc_robid", bus.wb_robid, 7'h7F);
      tick();
      @(negedge clk);
      chk("exc_wrap_robid", bus.wb_robid, 7'h00);
      chk("exc_wrap_error", bus.wb_error, 0);
      repeat (3) tick();

      // Flush with slots 0 and 2 full; unit 1 beat in the flush cycle is dropped
      drive(0, 1'b0, 5'd0, 7'h50, 32'h5000_0000);
      drive(2, 1'b0, 5'd0, 7'h52, 32'h5000_0002);
      tick();
      bus.req_valid = '0;
      drive(1, 1'b0, 5'd0, 7'h61, 32'h6100_0000);
      rob_flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", bus.req_ready, 4'h0);
      tick();
      rob_flush = 1'b0;
      bus.req_valid = '0;
      drive(3, 1'b0, 5'd0, 7'h63, 32'h6300_0003);
      push(1'b0, 5'd0, 7'h63, 32'h6300_0003);
      @(negedge clk);
      chk("flush_t1_idle", bus.wb_valid, 0);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("flush_t2_idle", bus.wb_valid, 0);
      tick();
      @(negedge clk);
      chk("flush_t3_vld", bus.wb_valid, 1);
      chk("flush_t3_robid", bus.wb_robid, 7'h63);
      repeat (3) tick();

      // Async reset mid-stream: unit 3 writes back, unit 1 pending in its slot
      drive(3, 1'b0, 5'd0, 7'h70, 32'h7000_0003);
      push(1'b0, 5'd0, 7'h70, 32'h7000_0003);
      tick();
      bus.req_valid = '0;
      drive(1, 1'b0, 5'd0, 7'h71, 32'h7100_0001);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("arst_pre_vld", bus.wb_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_vld_drop", bus.wb_valid, 0);
      chk("arst_robid_clr", bus.wb_robid, 0);
      chk("arst_result_clr", bus.wb_result, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         chk("arst_quiet", bus.wb_valid, 0);
         tick();
      end
      chk("arst_ready", bus.req_ready, 4'hF);
      drive(1, 1'b0, 5'd0, 7'h2A, 32'h2A2A_2A2A);
      push(1'b0, 5'd0, 7'h2A, 32'h2A2A_2A2A);
      tick();
      bus.req_valid = '0;
      tick();
      @(negedge clk);
      chk("arst_new_vld", bus.wb_valid, 1);
      chk("arst_new_robid", bus.wb_robid, 7'h2A);

      repeat (4) tick();
      chk("scoreboard_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the ROB's single writeback port (wb_valid/wb_error/wb_ecause/wb_robid/wb_result) between NUM_REQ execution units: ALU, branch, LSU, mul/div.
- Each requester has a one-entry holding slot. A round-robin arbiter drains one slot per cycle into a registered writeback stage.
- Pending writebacks are discarded on rob_flush.

Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8).
- ROBID_W, 7, ROB index width.
- ECAUSE_W, 5, exception cause width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rob_flush  in  1  pipeline flush from ROB.
- req_valid  in  NUM_REQ  per-unit writeback request.
- req_ready  out  NUM_REQ  per-unit slot can accept this cycle.
- req_error  in  NUM_REQ  per-unit exception flag.
- req_ecause  in  NUM_REQ*ECAUSE_W  per-unit cause; unit i at [(i+1)*ECAUSE_W-1 : i*ECAUSE_W].
- req_robid  in  NUM_REQ*ROBID_W  per-unit ROB index, same packing.
- req_result  in  NUM_REQ*32  per-unit result, same packing.
- wb_valid  out  1  writeback to ROB valid.
- wb_error  out  1  writeback exception flag.
- wb_ecause  out  ECAUSE_W  writeback cause.
- wb_robid  out  ROBID_W  writeback ROB index.
- wb_result  out  32  writeback result.

Behaviour:
- Reset (async, rst=1):
  - All slots empty.
  - rr_ptr=0.
  - wb_valid=0; wb_error=0; wb_ecause=0; wb_robid=0; wb_result=0.
  - req_ready reads all-ones while rst is low and there is no flush.
- Slot i accepts data (beat) when req_valid[i] & req_ready[i]. Captures error, ecause, robid and result at the clock edge.
- Readiness: req_ready[i] = ~rob_flush & (~slot_valid[i] | grant[i]).
  - A full slot that is granted this cycle accepts new data in the same cycle (back-to-back throughput 1 per unit when uncontended).
- Arbitration (combinational, every cycle):
  - Candidates are slot_valid[i].
  - Search starts at rr_ptr, ascending with wrap-around; the first valid slot wins.
  - At most one grant per cycle. grant is all-zero when no slot is valid.
- Pointer update: on any grant to unit g, rr_ptr <= (g+1) mod NUM_REQ. No grant leaves rr_ptr unchanged. rr_ptr is not reset by flush.
- Output stage: registered.
  - wb_valid <= |grant & ~rob_flush.
  - wb_* data <= the granted slot's fields. Data is held (not cleared) when there is no grant.
- Latency:
  - Request beat at cycle t, slot valid at t+1.
  - If granted at t+1, wb_valid=1 during t+2. Minimum latency is 2 cycles.
- Fairness: a valid slot is granted within NUM_REQ cycles of becoming valid, regardless of other traffic.
- Slot release:
  - A granted slot clears at the edge unless refilled in the same cycle.
  - Refill and grant in the same cycle leaves the slot valid, holding the new data.
- Flush (rob_flush=1 in cycle t):
  - All slots clear at the edge.
  - wb_valid=0 in t+1.
  - Any req_valid in cycle t is dropped (req_ready=0).
  - The grant made in cycle t is discarded.
  - wb_valid already high in cycle t is not suppressed; the ROB ignores it.
- No ordering guarantee between units; within one unit, writebacks leave in acceptance order.
- Reset asserted mid-operation: all state clears immediately; no partial writeback is emitted.

Decomposition:
- Shared package core_pkg:
  - ROBID_W=7, ECAUSE_W=5, XLEN=32.
  - wb_req struct/typedef {error, ecause, robid, result}.
- One sub-module rr_arbiter:
  - Parameter N; inputs req[N] and ptr; output onehot grant[N] and grant index.
  - Reusable by future issue-port arbitration.
- Slots and output register live in wb_arbiter.

Test Plan:
- Single request: unit 2 req_valid=1, robid=0x15, result=0xDEADBEEF at t0 -> wb_valid=1, wb_robid=0x15, wb_result=0xDEADBEEF at t0+2; req_ready[2] stays 1.
- Contention: units 0..3 all request at t0, rr_ptr=0 -> wb_robid order unit0, unit1, unit2, unit3 on t0+2..t0+5; rr_ptr ends at 0.
- Streaming plus fairness: unit 0 requests every cycle while unit 3 requests once -> unit 3 written back within 4 cycles; unit 0 loses exactly one slot cycle (req_ready[0]=0 for one cycle).
- Exception pass-through: unit 1 error=1, ecause=5'd2, robid=0x7F -> wb_error=1, wb_ecause=2, wb_robid=0x7F; robid wrap value is handled.
- Flush: slots 0 and 2 full, rob_flush=1 at t -> req_ready=0 at t, wb_valid=0 at t+1 and t+2, slots empty; a new request at t+1 writes back at t+3.
- Async reset: assert rst mid-stream between clock edges -> wb_valid drops immediately, no writeback after release until a new request.
